// File: rtl/riscv_regfile_wb_arbiter_pkg.sv
// riscv_wb_pkg: shared widths, x0 constant and arbiter state encoding for the writeback arbiter
package riscv_wb_pkg;
  localparam int REG_W = 5;
  localparam int DATA_W = 32;
  localparam int NREG = 32;
  localparam logic [REG_W-1:0] REG_ZERO = '0;
  typedef enum logic {PRIO_A = 1'b0, PRIO_B = 1'b1} arb_state_e;
endpackage

// File: rtl/riscv_regfile_wb_arbiter_if.sv
// riscv_regfile_wb_arbiter_if: writeback requests, issue/hazard lookups, register-file write and forwarding bundle
// slave: arbiter side (takes requests, drives ready/busy/rd0/fwd); master: requester/register-file side
interface riscv_regfile_wb_arbiter_if;
  import riscv_wb_pkg::*;
  logic              wb_a_valid_i;
  logic [REG_W-1:0]  wb_a_rd_i;
  logic [DATA_W-1:0] wb_a_value_i;
  logic              wb_a_ready_o;
  logic              wb_b_valid_i;
  logic [REG_W-1:0]  wb_b_rd_i;
  logic [DATA_W-1:0] wb_b_value_i;
  logic              wb_b_ready_o;
  logic              issue_valid_i;
  logic [REG_W-1:0]  issue_rd_i;
  logic [REG_W-1:0]  ra_i;
  logic [REG_W-1:0]  rb_i;
  logic              ra_busy_o;
  logic              rb_busy_o;
  logic [NREG-1:0]   busy_o;
  logic [REG_W-1:0]  rd0_o;
  logic [DATA_W-1:0] rd0_value_o;
  logic              fwd_a_valid_o;
  logic              fwd_b_valid_o;
  logic [DATA_W-1:0] fwd_value_o;
  modport slave (
    input  wb_a_valid_i, wb_a_rd_i, wb_a_value_i, wb_b_valid_i, wb_b_rd_i, wb_b_value_i,
           issue_valid_i, issue_rd_i, ra_i, rb_i,
    output wb_a_ready_o, wb_b_ready_o, ra_busy_o, rb_busy_o, busy_o, rd0_o, rd0_value_o,
           fwd_a_valid_o, fwd_b_valid_o, fwd_value_o
  );
  modport master (
    output wb_a_valid_i, wb_a_rd_i, wb_a_value_i, wb_b_valid_i, wb_b_rd_i, wb_b_value_i,
           issue_valid_i, issue_rd_i, ra_i, rb_i,
    input  wb_a_ready_o, wb_b_ready_o, ra_busy_o, rb_busy_o, busy_o, rd0_o, rd0_value_o,
           fwd_a_valid_o, fwd_b_valid_o, fwd_value_o
  );
endinterface

// File: rtl/riscv_regfile_wb_arbiter_scoreboard.sv
// riscv_wb_scoreboard: pending-write mask for long-latency results with two combinational lookups
// ports: set_en/set_idx (issue), clr_en/clr_idx (B grant), ra/rb lookups -> ra_busy/rb_busy, busy mask (bit 0 tied 0)
module riscv_wb_scoreboard
  import riscv_wb_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             set_en,
  input  logic [REG_W-1:0] set_idx,
  input  logic             clr_en,
  input  logic [REG_W-1:0] clr_idx,
  input  logic [REG_W-1:0] ra,
  input  logic [REG_W-1:0] rb,
  output logic [NREG-1:0]  busy,
  output logic             ra_busy,
  output logic             rb_busy
);
  logic [NREG-1:1] busy_q;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) busy_q <= '0;
    // set is applied after clear so an issue colliding with a retire keeps the bit
    else for (int i = 1; i < NREG; i++)
      busy_q[i] <= (busy_q[i] && !(clr_en && clr_idx == REG_W'(i))) || (set_en && set_idx == REG_W'(i));
  end
  assign busy = {busy_q, 1'b0};
  assign ra_busy = busy[ra];
  assign rb_busy = busy[rb];
endmodule

// File: rtl/riscv_regfile_wb_arbiter.sv
// riscv_regfile_wb_arbiter: shares the register-file write port between in-order (A) and long-latency (B) writeback
// ports: clk_i, rst_i (async, active-high), bus (riscv_regfile_wb_arbiter_if.slave)
// RISCV_WB_ARB_FWD_EN: when defined, exposes the in-flight write on the fwd_* outputs; otherwise they are 0
module riscv_regfile_wb_arbiter
  import riscv_wb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W = 4
) (
  input logic clk_i,
  input logic rst_i,
  riscv_regfile_wb_arbiter_if.slave bus
);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);
  arb_state_e state;
  logic [CNT_W-1:0] cnt, cnt_inc;
  logic [REG_W-1:0] rd0_q;
  logic [DATA_W-1:0] rd0_value_q;
  logic a_req, b_req, grant_a, grant_b, b_held;
  always_comb begin
    a_req = bus.wb_a_valid_i && bus.wb_a_rd_i != REG_ZERO;
    b_req = bus.wb_b_valid_i && bus.wb_b_rd_i != REG_ZERO;
    grant_a = a_req && (!b_req || state == PRIO_A);
    grant_b = b_req && (!a_req || state == PRIO_B);
    b_held = b_req && !grant_b;
    cnt_inc = (cnt >= LIMIT) ? LIMIT : cnt + CNT_W'(1);
  end
  // x0 writes are acknowledged at once and never take the port
  assign bus.wb_a_ready_o = bus.wb_a_valid_i && (bus.wb_a_rd_i == REG_ZERO || grant_a);
  assign bus.wb_b_ready_o = bus.wb_b_valid_i && (bus.wb_b_rd_i == REG_ZERO || grant_b);
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= PRIO_A;
      cnt <= '0;
      rd0_q <= REG_ZERO;
      rd0_value_q <= '0;
    end else begin
      cnt <= b_held ? cnt_inc : '0;
      // flip as the hold-off count reaches the limit so B wins on the very next cycle
      state <= (state == PRIO_A && b_held && cnt_inc == LIMIT) ? PRIO_B :
               (state == PRIO_B && (grant_b || !bus.wb_b_valid_i)) ? PRIO_A : state;
      rd0_q <= grant_a ? bus.wb_a_rd_i : grant_b ? bus.wb_b_rd_i : REG_ZERO;
      if (grant_a || grant_b) rd0_value_q <= grant_a ? bus.wb_a_value_i : bus.wb_b_value_i;
    end
  end
  assign bus.rd0_o = rd0_q;
  assign bus.rd0_value_o = rd0_value_q;
  riscv_wb_scoreboard u_sb (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .set_en(bus.issue_valid_i && bus.issue_rd_i != REG_ZERO),
    .set_idx(bus.issue_rd_i),
    .clr_en(grant_b),
    .clr_idx(bus.wb_b_rd_i),
    .ra(bus.ra_i),
    .rb(bus.rb_i),
    .busy(bus.busy_o),
    .ra_busy(bus.ra_busy_o),
    .rb_busy(bus.rb_busy_o)
  );
`ifdef RISCV_WB_ARB_FWD_EN
  assign bus.fwd_a_valid_o = rd0_q != REG_ZERO && rd0_q == bus.ra_i;
  assign bus.fwd_b_valid_o = rd0_q != REG_ZERO && rd0_q == bus.rb_i;
  assign bus.fwd_value_o = rd0_value_q;
`else
  assign bus.fwd_a_valid_o = 1'b0;
  assign bus.fwd_b_valid_o = 1'b0;
  assign bus.fwd_value_o = '0;
`endif
endmodule
